// File: rtl/rob_commit_pkg.sv
// Shared types and sizing for the reorder buffer commit block.
package rob_commit_pkg;
  localparam int ROB_DEPTH = 16;
  localparam int PREG_W    = 6;
  localparam int AREG_W    = 5;
  localparam int DATA_W    = 32;
  localparam int NUM_CMP   = 3;

  localparam logic [6:0] OP_SW = 7'b0100011;

  typedef struct packed {
    logic              v;
    logic              done;
    logic              store;
    logic [AREG_W-1:0] rd;
    logic [PREG_W-1:0] pd;
    logic [PREG_W-1:0] old_pd;
    logic [DATA_W-1:0] data;
  } rob_entry_t;

  typedef struct packed {
    logic              store;
    logic [AREG_W-1:0] rd;
    logic [PREG_W-1:0] pd;
    logic [PREG_W-1:0] old_pd;
    logic [DATA_W-1:0] data;
  } rob_ret_t;
endpackage

// File: rtl/rob_cmp_match.sv
// Per-entry tag match against all completion ports; lowest port wins on a tie.
module rob_cmp_match
  import rob_commit_pkg::*;
(
  input  logic                             v_i,
  input  logic                             done_i,
  input  logic [PREG_W-1:0]                pd_i,
  input  logic [NUM_CMP-1:0]               cmp_valid_i,
  input  logic [NUM_CMP-1:0][PREG_W-1:0]   cmp_dest_i,
  input  logic [NUM_CMP-1:0][DATA_W-1:0]   cmp_data_i,
  output logic                             hit_o,
  output logic [DATA_W-1:0]                data_o
);
  // Scan from the highest port down so the lowest matching port is applied last.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    for (int k = NUM_CMP-1; k >= 0; k--) begin
      if (v_i && !done_i && cmp_valid_i[k] && (cmp_dest_i[k] == pd_i)) begin
        hit_o  = 1'b1;
        data_o = cmp_data_i[k];
      end
    end
  end
endmodule

// File: rtl/rob_commit.sv
// Circular ROB: dual in-order allocate, triple tag-matched completion, dual in-order retire.
// Optional flush port enabled by defining ROB_COMMIT_FLUSH_EN.
module rob_commit
  import rob_commit_pkg::*;
#(
  parameter int DEPTH = ROB_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
`ifdef ROB_COMMIT_FLUSH_EN
  input  logic                    flush,
`endif
  input  logic                    alloc_en_1,
  input  logic                    alloc_en_2,
  input  logic [PREG_W-1:0]       alloc_pd_1,
  input  logic [PREG_W-1:0]       alloc_pd_2,
  input  logic [PREG_W-1:0]       alloc_old_pd_1,
  input  logic [PREG_W-1:0]       alloc_old_pd_2,
  input  logic [AREG_W-1:0]       alloc_rd_1,
  input  logic [AREG_W-1:0]       alloc_rd_2,
  input  logic                    alloc_store_1,
  input  logic                    alloc_store_2,
  output logic                    alloc_ready,
  output logic [$clog2(DEPTH)-1:0] alloc_idx_1,
  output logic [$clog2(DEPTH)-1:0] alloc_idx_2,
  input  logic                    cmp_valid_1,
  input  logic                    cmp_valid_2,
  input  logic                    cmp_valid_3,
  input  logic [PREG_W-1:0]       cmp_dest_1,
  input  logic [PREG_W-1:0]       cmp_dest_2,
  input  logic [PREG_W-1:0]       cmp_dest_3,
  input  logic [DATA_W-1:0]       cmp_data_1,
  input  logic [DATA_W-1:0]       cmp_data_2,
  input  logic [DATA_W-1:0]       cmp_data_3,
  output logic                    ret_valid_1,
  output logic                    ret_valid_2,
  output logic [AREG_W-1:0]       ret_rd_1,
  output logic [AREG_W-1:0]       ret_rd_2,
  output logic [PREG_W-1:0]       ret_pd_1,
  output logic [PREG_W-1:0]       ret_pd_2,
  output logic [PREG_W-1:0]       ret_old_pd_1,
  output logic [PREG_W-1:0]       ret_old_pd_2,
  output logic [DATA_W-1:0]       ret_data_1,
  output logic [DATA_W-1:0]       ret_data_2,
  output logic                    ret_store_1,
  output logic                    ret_store_2,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    empty
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam logic [PTR_W-1:0] RDY_MAX = PTR_W'(DEPTH - 2);

  rob_entry_t        ent_q [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [PTR_W-1:0]  cnt;
  logic [IDX_W-1:0]  head_idx, head1_idx, tail_idx, tail1_idx;
  logic              ret1, ret2, alloc_go, alloc_two, flush_w;
  logic [DEPTH-1:0]  hit, clr_vec, wr1_vec, wr2_vec;
  logic [DEPTH-1:0][DATA_W-1:0] hit_data;
  logic [NUM_CMP-1:0]             cmp_v;
  logic [NUM_CMP-1:0][PREG_W-1:0] cmp_t;
  logic [NUM_CMP-1:0][DATA_W-1:0] cmp_d;
  rob_entry_t        new1, new2;
  rob_ret_t          ret1_q, ret2_q;
  logic              rv1_q, rv2_q;

`ifdef ROB_COMMIT_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  // Wrap bit in the pointers lets tail - head range over 0..DEPTH.
  assign cnt         = tail_q - head_q;
  assign count       = cnt;
  assign empty       = (cnt == '0);
  assign alloc_ready = (cnt <= RDY_MAX);

  assign head_idx  = head_q[IDX_W-1:0];
  assign head1_idx = head_idx + 1'b1;
  assign tail_idx  = tail_q[IDX_W-1:0];
  assign tail1_idx = tail_idx + 1'b1;
  assign alloc_idx_1 = tail_idx;
  assign alloc_idx_2 = tail1_idx;

  assign ret1      = ent_q[head_idx].v && ent_q[head_idx].done;
  assign ret2      = ret1 && ent_q[head1_idx].v && ent_q[head1_idx].done;
  assign alloc_go  = alloc_en_1 && alloc_ready;
  assign alloc_two = alloc_go && alloc_en_2;

  assign clr_vec = (DEPTH'(ret1) << head_idx) | (DEPTH'(ret2) << head1_idx);
  assign wr1_vec = DEPTH'(alloc_go) << tail_idx;
  assign wr2_vec = DEPTH'(alloc_two) << tail1_idx;

  assign new1 = '{v: 1'b1, done: 1'b0, store: alloc_store_1, rd: alloc_rd_1,
                  pd: alloc_pd_1, old_pd: alloc_old_pd_1, data: '0};
  assign new2 = '{v: 1'b1, done: 1'b0, store: alloc_store_2, rd: alloc_rd_2,
                  pd: alloc_pd_2, old_pd: alloc_old_pd_2, data: '0};

  assign cmp_v = {cmp_valid_3, cmp_valid_2, cmp_valid_1};
  assign cmp_t = {cmp_dest_3, cmp_dest_2, cmp_dest_1};
  assign cmp_d = {cmp_data_3, cmp_data_2, cmp_data_1};

  for (genvar g = 0; g < DEPTH; g++) begin : g_match
    rob_cmp_match u_match (
      .v_i         (ent_q[g].v),
      .done_i      (ent_q[g].done),
      .pd_i        (ent_q[g].pd),
      .cmp_valid_i (cmp_v),
      .cmp_dest_i  (cmp_t),
      .cmp_data_i  (cmp_d),
      .hit_o       (hit[g]),
      .data_o      (hit_data[g])
    );
  end

  always_comb begin
    head_d = head_q + PTR_W'(ret1) + PTR_W'(ret2);
    tail_d = tail_q + PTR_W'(alloc_go) + PTR_W'(alloc_two);
    if (flush_w) begin
      head_d = head_q;
      tail_d = head_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  // Alloc, retire and completion never target the same entry in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (flush_w) begin
          ent_q[i].v    <= 1'b0;
          ent_q[i].done <= 1'b0;
        end else if (wr1_vec[i]) begin
          ent_q[i] <= new1;
        end else if (wr2_vec[i]) begin
          ent_q[i] <= new2;
        end else if (clr_vec[i]) begin
          ent_q[i].v    <= 1'b0;
          ent_q[i].done <= 1'b0;
        end else if (hit[i]) begin
          ent_q[i].done <= 1'b1;
          ent_q[i].data <= hit_data[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rv1_q  <= 1'b0;
      rv2_q  <= 1'b0;
      ret1_q <= '0;
      ret2_q <= '0;
    end else begin
      rv1_q <= ret1 && !flush_w;
      rv2_q <= ret2 && !flush_w;
      if (ret1 && !flush_w)
        ret1_q <= '{store: ent_q[head_idx].store, rd: ent_q[head_idx].rd,
                    pd: ent_q[head_idx].pd, old_pd: ent_q[head_idx].old_pd,
                    data: ent_q[head_idx].data};
      if (ret2 && !flush_w)
        ret2_q <= '{store: ent_q[head1_idx].store, rd: ent_q[head1_idx].rd,
                    pd: ent_q[head1_idx].pd, old_pd: ent_q[head1_idx].old_pd,
                    data: ent_q[head1_idx].data};
    end
  end

  assign ret_valid_1  = rv1_q;
  assign ret_valid_2  = rv2_q;
  assign ret_store_1  = ret1_q.store;
  assign ret_store_2  = ret2_q.store;
  assign ret_rd_1     = ret1_q.rd;
  assign ret_rd_2     = ret2_q.rd;
  assign ret_pd_1     = ret1_q.pd;
  assign ret_pd_2     = ret2_q.pd;
  assign ret_old_pd_1 = ret1_q.old_pd;
  assign ret_old_pd_2 = ret2_q.old_pd;
  assign ret_data_1   = ret1_q.data;
  assign ret_data_2   = ret2_q.data;
endmodule

// File: tb/tb_rob_commit.sv
// Bench for rob_commit: vector table plus a queue model of in-flight entries.
module tb_rob_commit;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
`ifdef ROB_COMMIT_FLUSH_EN
  logic flush;
`endif
  logic alloc_en_1, alloc_en_2, alloc_store_1, alloc_store_2;
  logic [5:0] alloc_pd_1, alloc_pd_2, alloc_old_pd_1, alloc_old_pd_2;
  logic [4:0] alloc_rd_1, alloc_rd_2;
  logic cmp_valid_1, cmp_valid_2, cmp_valid_3;
  logic [5:0] cmp_dest_1, cmp_dest_2, cmp_dest_3;
  logic [31:0] cmp_data_1, cmp_data_2, cmp_data_3;
  logic alloc_ready, ret_valid_1, ret_valid_2, ret_store_1, ret_store_2, empty;
  logic [3:0] alloc_idx_1, alloc_idx_2;
  logic [4:0] ret_rd_1, ret_rd_2, count;
  logic [5:0] ret_pd_1, ret_pd_2, ret_old_pd_1, ret_old_pd_2;
  logic [31:0] ret_data_1, ret_data_2;

  rob_commit #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef ROB_COMMIT_FLUSH_EN
    .flush(flush),
`endif
    .alloc_en_1(alloc_en_1), .alloc_en_2(alloc_en_2),
    .alloc_pd_1(alloc_pd_1), .alloc_pd_2(alloc_pd_2),
    .alloc_old_pd_1(alloc_old_pd_1), .alloc_old_pd_2(alloc_old_pd_2),
    .alloc_rd_1(alloc_rd_1), .alloc_rd_2(alloc_rd_2),
    .alloc_store_1(alloc_store_1), .alloc_store_2(alloc_store_2),
    .alloc_ready(alloc_ready), .alloc_idx_1(alloc_idx_1), .alloc_idx_2(alloc_idx_2),
    .cmp_valid_1(cmp_valid_1), .cmp_valid_2(cmp_valid_2), .cmp_valid_3(cmp_valid_3),
    .cmp_dest_1(cmp_dest_1), .cmp_dest_2(cmp_dest_2), .cmp_dest_3(cmp_dest_3),
    .cmp_data_1(cmp_data_1), .cmp_data_2(cmp_data_2), .cmp_data_3(cmp_data_3),
    .ret_valid_1(ret_valid_1), .ret_valid_2(ret_valid_2),
    .ret_rd_1(ret_rd_1), .ret_rd_2(ret_rd_2), .ret_pd_1(ret_pd_1), .ret_pd_2(ret_pd_2),
    .ret_old_pd_1(ret_old_pd_1), .ret_old_pd_2(ret_old_pd_2),
    .ret_data_1(ret_data_1), .ret_data_2(ret_data_2),
    .ret_store_1(ret_store_1), .ret_store_2(ret_store_2),
    .count(count), .empty(empty)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [5:0]  pd;
    logic [5:0]  old_pd;
    logic        st;
    logic        done;
    logic [31:0] data;
  } sb_t;

  typedef struct {
    bit a1, a2;
    logic [5:0] p1, p2;
    logic [2:0] cv;
    logic [5:0] t1, t2, t3;
    logic [31:0] d1, d2, d3;
    int ecnt;
    bit erv1, erv2;
  } vec_t;

  sb_t  sbq[$];
  vec_t vt[$];
  int   mtail = 0;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
`ifdef ROB_COMMIT_FLUSH_EN
    flush = 1'b0;
`endif
    alloc_en_1 = 0; alloc_en_2 = 0;
    alloc_pd_1 = 0; alloc_pd_2 = 0; alloc_old_pd_1 = 0; alloc_old_pd_2 = 0;
    alloc_rd_1 = 0; alloc_rd_2 = 0; alloc_store_1 = 0; alloc_store_2 = 0;
    cmp_valid_1 = 0; cmp_valid_2 = 0; cmp_valid_3 = 0;
    cmp_dest_1 = 0; cmp_dest_2 = 0; cmp_dest_3 = 0;
    cmp_data_1 = 0; cmp_data_2 = 0; cmp_data_3 = 0;
  endtask

  // Other fields are derived from the pd so every entry is distinguishable.
  task automatic drv_alloc(input bit a1, input bit a2, input logic [5:0] p1, input logic [5:0] p2);
    alloc_en_1 = a1; alloc_en_2 = a2;
    alloc_pd_1 = p1; alloc_rd_1 = p1[4:0] + 5'd4; alloc_old_pd_1 = ~p1; alloc_store_1 = &p1[1:0];
    alloc_pd_2 = p2; alloc_rd_2 = p2[4:0] + 5'd4; alloc_old_pd_2 = ~p2; alloc_store_2 = &p2[1:0];
  endtask

  task automatic mcmp(input logic v, input logic [5:0] t, input logic [31:0] d);
    if (v) begin
      foreach (sbq[j]) begin
        if (!sbq[j].done && sbq[j].pd == t) begin
          sbq[j].done = 1'b1;
          sbq[j].data = d;
          break;
        end
      end
    end
  endtask

  // Advance the model from pre-edge state, clock once, then compare.
  task automatic cyc();
    bit r1, r2, rdy, fl;
    sb_t e1, e2, n;
    fl = 1'b0;
`ifdef ROB_COMMIT_FLUSH_EN
    fl = flush;
`endif
    rdy = (sbq.size() <= DEPTH - 2);
    if (alloc_en_1 && rdy && !fl) chk("alloc_idx_1", alloc_idx_1, mtail);
    if (alloc_en_1 && alloc_en_2 && rdy && !fl) chk("alloc_idx_2", alloc_idx_2, (mtail + 1) % DEPTH);
    r1 = !fl && sbq.size() > 0 && sbq[0].done;
    r2 = r1 && sbq.size() > 1 && sbq[1].done;
    if (r1) e1 = sbq[0];
    if (r2) e2 = sbq[1];
    if (fl) begin
      mtail = (mtail - sbq.size() + DEPTH) % DEPTH;
      sbq.delete();
    end else begin
      mcmp(cmp_valid_1, cmp_dest_1, cmp_data_1);
      mcmp(cmp_valid_2, cmp_dest_2, cmp_data_2);
      mcmp(cmp_valid_3, cmp_dest_3, cmp_data_3);
      if (r1) void'(sbq.pop_front());
      if (r2) void'(sbq.pop_front());
      if (alloc_en_1 && rdy) begin
        n = '{rd: alloc_rd_1, pd: alloc_pd_1, old_pd: alloc_old_pd_1, st: alloc_store_1, done: 1'b0, data: 32'h0};
        sbq.push_back(n);
        mtail = (mtail + 1) % DEPTH;
        if (alloc_en_2) begin
          n = '{rd: alloc_rd_2, pd: alloc_pd_2, old_pd: alloc_old_pd_2, st: alloc_store_2, done: 1'b0, data: 32'h0};
          sbq.push_back(n);
          mtail = (mtail + 1) % DEPTH;
        end
      end
    end
    @(posedge clk); #1;
    chk("ret_valid_1", ret_valid_1, r1);
    chk("ret_valid_2", ret_valid_2, r2);
    if (r1) chk("ret1_fields", {ret_rd_1, ret_pd_1, ret_old_pd_1, ret_store_1, ret_data_1},
                {e1.rd, e1.pd, e1.old_pd, e1.st, e1.data});
    if (r2) chk("ret2_fields", {ret_rd_2, ret_pd_2, ret_old_pd_2, ret_store_2, ret_data_2},
                {e2.rd, e2.pd, e2.old_pd, e2.st, e2.data});
    chk("count", count, sbq.size());
    chk("alloc_ready", alloc_ready, sbq.size() <= DEPTH - 2);
    chk("empty", empty, sbq.size() == 0);
  endtask

  // Completes the oldest pending entry each cycle until the model is empty.
  task automatic drain();
    for (int i = 0; i < 60 && sbq.size() > 0; i++) begin
      idle();
      foreach (sbq[j]) begin
        if (!sbq[j].done) begin
          cmp_valid_1 = 1'b1; cmp_dest_1 = sbq[j].pd; cmp_data_1 = $urandom;
          break;
        end
      end
      cyc();
    end
    idle();
    chk("drain_empty", empty, 1'b1);
  endtask

  function automatic vec_t mk(bit a1, bit a2, logic [5:0] p1, logic [5:0] p2, logic [2:0] cv,
                              logic [5:0] t1, logic [5:0] t2, logic [5:0] t3,
                              logic [31:0] d1, logic [31:0] d2, logic [31:0] d3,
                              int ecnt, bit erv1, bit erv2);
    vec_t v;
    v = '{a1: a1, a2: a2, p1: p1, p2: p2, cv: cv, t1: t1, t2: t2, t3: t3,
          d1: d1, d2: d2, d3: d3, ecnt: ecnt, erv1: erv1, erv2: erv2};
    return v;
  endfunction

  initial begin
    // a1 a2 p1 p2 cv t1 t2 t3 d1 d2 d3 -> count rv1 rv2 after the edge
    vt.push_back(mk(0,0, 0, 0, 3'b000,  0, 0, 0, 0, 0, 0, 0,0,0));
    vt.push_back(mk(1,0,33, 0, 3'b000,  0, 0, 0, 0, 0, 0, 1,0,0));
    vt.push_back(mk(1,0,34, 0, 3'b000,  0, 0, 0, 0, 0, 0, 2,0,0));
    vt.push_back(mk(0,0, 0, 0, 3'b001, 34, 0, 0, 32'h5, 0, 0, 2,0,0));
    vt.push_back(mk(0,0, 0, 0, 3'b001, 33, 0, 0, 32'h7, 0, 0, 2,0,0));
    vt.push_back(mk(0,0, 0, 0, 3'b000,  0, 0, 0, 0, 0, 0, 0,1,1));
    vt.push_back(mk(0,0, 0, 0, 3'b000,  0, 0, 0, 0, 0, 0, 0,0,0));
    vt.push_back(mk(1,1,40,41, 3'b000,  0, 0, 0, 0, 0, 0, 2,0,0));
    vt.push_back(mk(1,0,42, 0, 3'b000,  0, 0, 0, 0, 0, 0, 3,0,0));
    vt.push_back(mk(0,0, 0, 0, 3'b111, 41,42,40, 32'h141, 32'h142, 32'h140, 3,0,0));
    vt.push_back(mk(0,0, 0, 0, 3'b000,  0, 0, 0, 0, 0, 0, 1,1,1));
    vt.push_back(mk(0,0, 0, 0, 3'b000,  0, 0, 0, 0, 0, 0, 0,1,0));
    vt.push_back(mk(0,0, 0, 0, 3'b000,  0, 0, 0, 0, 0, 0, 0,0,0));
    vt.push_back(mk(1,0,50, 0, 3'b000,  0, 0, 0, 0, 0, 0, 1,0,0));
    vt.push_back(mk(0,0, 0, 0, 3'b111, 50,50,63, 32'hAA, 32'hBB, 32'hCC, 1,0,0));
    vt.push_back(mk(0,0, 0, 0, 3'b000,  0, 0, 0, 0, 0, 0, 0,1,0));
    vt.push_back(mk(0,1, 0,55, 3'b000,  0, 0, 0, 0, 0, 0, 0,0,0));
    vt.push_back(mk(1,0,56, 0, 3'b001, 56, 0, 0, 32'h11, 0, 0, 1,0,0));
    vt.push_back(mk(0,0, 0, 0, 3'b000,  0, 0, 0, 0, 0, 0, 1,0,0));
    vt.push_back(mk(0,0, 0, 0, 3'b001, 56, 0, 0, 32'h99, 0, 0, 1,0,0));
    vt.push_back(mk(0,0, 0, 0, 3'b000,  0, 0, 0, 0, 0, 0, 0,1,0));

    idle();
    rst_n = 1'b0;
    #12;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1'b1);
    chk("rst_rv1", ret_valid_1, 1'b0);
    chk("rst_rv2", ret_valid_2, 1'b0);
    @(negedge clk) rst_n = 1'b1;

    foreach (vt[i]) begin
      idle();
      drv_alloc(vt[i].a1, vt[i].a2, vt[i].p1, vt[i].p2);
      cmp_valid_1 = vt[i].cv[0]; cmp_dest_1 = vt[i].t1; cmp_data_1 = vt[i].d1;
      cmp_valid_2 = vt[i].cv[1]; cmp_dest_2 = vt[i].t2; cmp_data_2 = vt[i].d2;
      cmp_valid_3 = vt[i].cv[2]; cmp_dest_3 = vt[i].t3; cmp_data_3 = vt[i].d3;
      cyc();
      chk("vec_count", count, vt[i].ecnt);
      chk("vec_rv", {ret_valid_1, ret_valid_2}, {vt[i].erv1, vt[i].erv2});
    end

    // Fill to capacity with dual allocs.
    for (int i = 0; i < 8; i++) begin
      idle();
      drv_alloc(1, 1, 6'(2*i), 6'(2*i+1));
      cyc();
      if (i == 6) chk("fill14_ready", {count, alloc_ready}, {5'd14, 1'b1});
    end
    chk("full_ready", {count, alloc_ready}, {5'd16, 1'b0});
    idle(); drv_alloc(1, 1, 60, 61); cyc();
    chk("full_ignored", count, 5'd16);
    idle(); cmp_valid_1 = 1; cmp_dest_1 = 0; cmp_data_1 = 32'hD0; cyc();
    idle(); drv_alloc(1, 0, 62, 0); cmp_valid_1 = 1; cmp_dest_1 = 1; cmp_data_1 = 32'hD1; cyc();
    chk("cnt15_ready", {count, alloc_ready}, {5'd15, 1'b0});
    idle(); cyc();
    chk("cnt14_ready", {count, alloc_ready}, {5'd14, 1'b1});
    drain();

    // Steady alloc/complete stream drives the pointers through the wrap.
    for (int i = 0; i < 20; i++) begin
      idle();
      drv_alloc(1, 0, 6'(20 + i), 0);
      if (i > 0) begin cmp_valid_1 = 1; cmp_dest_1 = 6'(19 + i); cmp_data_1 = 32'h1000 + i; end
      cyc();
    end
    drain();

    // Async reset while a retire is showing and 5 entries are live.
    idle(); drv_alloc(1, 1, 1, 2); cyc();
    idle(); drv_alloc(1, 1, 3, 4); cyc();
    idle(); drv_alloc(1, 1, 5, 6); cmp_valid_1 = 1; cmp_dest_1 = 1; cmp_data_1 = 32'hAB; cyc();
    idle(); cyc();
    chk("pre_rst_state", {count, ret_valid_1}, {5'd5, 1'b1});
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_count", count, 0);
    chk("async_rst_rv", {ret_valid_1, ret_valid_2, empty}, 3'b001);
    sbq.delete();
    mtail = 0;
    @(negedge clk) rst_n = 1'b1;
    idle(); cyc();

`ifdef ROB_COMMIT_FLUSH_EN
    idle(); drv_alloc(1, 1, 7, 8); cyc();
    idle(); flush = 1'b1; drv_alloc(1, 0, 9, 0); cmp_valid_1 = 1; cmp_dest_1 = 7; cyc();
    chk("flush_count", count, 0);
    idle(); drv_alloc(1, 0, 10, 0); cyc();
    drain();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
